// File: rtl/conv_column_streamer.sv
// rtl/conv_column_streamer.sv - streams 3-high pixel columns from a raster frame memory
// Two line buffers hold the previous rows; a 2-entry FIFO decouples the consumer.
module conv_column_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 224,
  parameter int IMG_H      = 224,
  parameter int ADDR_W     = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [3*DATA_WIDTH-1:0] mem_rd_data,
  output logic [3*DATA_WIDTH-1:0] col_r,
  output logic [3*DATA_WIDTH-1:0] col_g,
  output logic [3*DATA_WIDTH-1:0] col_b,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic                    col_eol,
  output logic                    col_last,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 3 * DW;
  localparam int EW = 9 * DW + 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] PRIME_END = ADDR_W'(2 * IMG_W - 1);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic              rd_pend;
  logic [CW-1:0]     ret_col;
  logic [RW-1:0]     ret_row;
  logic [PW-1:0]     lb0 [IMG_W];
  logic [PW-1:0]     lb1 [IMG_W];
  logic [EW-1:0]     fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              push, pop, issue, ret_eol;
  logic [PW-1:0]     px, up1, up2;
  logic [EW-1:0]     entry, head;

  assign px        = mem_rd_data;
  assign up1       = lb1[ret_col];
  assign up2       = lb0[ret_col];
  assign ret_eol   = (ret_col == CW'(IMG_W - 1));
  assign col_valid = (count != 2'd0);
  assign pop       = col_valid && col_ready;
  assign push      = rd_pend && (ret_row >= RW'(2));
  // Reads in flight plus queued columns must fit the FIFO once this cycle's pop is taken.
  assign issue     = ({1'b0, count} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop});
  assign busy      = (state != IDLE);
  assign mem_rd_addr = addr;

  assign entry = {ret_eol, ret_eol && (ret_row == RW'(IMG_H - 1)),
                  px[PW-1:2*DW],  up1[PW-1:2*DW],  up2[PW-1:2*DW],
                  px[2*DW-1:DW],  up1[2*DW-1:DW],  up2[2*DW-1:DW],
                  px[DW-1:0],     up1[DW-1:0],     up2[DW-1:0]};
  assign head = fifo_mem[rd_ptr];
  assign col_eol  = col_valid && head[EW-1];
  assign col_last = col_valid && head[EW-2];
  assign col_r    = head[9*DW-1:6*DW];
  assign col_g    = head[6*DW-1:3*DW];
  assign col_b    = head[3*DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = PRIME;
      PRIME: begin
        mem_rd_en = 1'b1;
        if (addr == PRIME_END) state_nxt = STREAM;
      end
      STREAM: begin
        mem_rd_en = issue;
        if (issue && addr == FRAME_END) state_nxt = FLUSH;
      end
      FLUSH:  if (pop && col_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) mem_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      rd_pend <= 1'b0;
      ret_col <= '0;
      ret_row <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      done    <= 1'b0;
    end else begin
      done    <= (state == FLUSH) && pop && col_last;
      rd_pend <= mem_rd_en;
      if (state == IDLE && start) begin
        addr    <= '0;
        ret_col <= '0;
        ret_row <= '0;
      end else begin
        if (mem_rd_en && addr != FRAME_END) addr <= addr + 1'b1;
        if (rd_pend) begin
          if (ret_eol) begin
            ret_col <= '0;
            ret_row <= ret_row + 1'b1;
          end else begin
            ret_col <= ret_col + 1'b1;
          end
        end
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage only; contents are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= entry;
    if (rd_pend) begin
      if (ret_row == RW'(0)) begin
        lb0[ret_col] <= px;
      end else if (ret_row == RW'(1)) begin
        lb1[ret_col] <= px;
      end else begin
        lb0[ret_col] <= up1;
        lb1[ret_col] <= px;
      end
    end
  end

endmodule

// File: tb/tb_conv_column_streamer.sv
// tb/tb_conv_column_streamer.sv - self-checking bench for conv_column_streamer
// Expected columns are derived from the frame's raster pixel values.
module tb_conv_column_streamer;
  localparam int W = 4, H = 4, DW = 8, AW = 18, NCOL = (H - 2) * W;

  logic          clk, rst, start, mem_rd_en, col_valid, col_ready, col_eol, col_last, busy, done;
  logic [AW-1:0] mem_rd_addr;
  logic [23:0]   mem_rd_data, col_r, col_g, col_b;

  conv_column_streamer #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .col_valid(col_valid), .col_ready(col_ready), .col_eol(col_eol), .col_last(col_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int idx, xfers, done_cnt, stream_issued;
  int ready_mode = 0, pat_i = 0;
  logic [23:0] first_r, first_b, last_r;
  logic        last_eol, last_last, prev_stall;
  logic [73:0] saved;

  function automatic logic [23:0] pix(input int a);
    logic [7:0] r, g, b;
    r = 8'(a);
    g = 8'(a + 64);
    b = 8'(a + 128);
    return {r, g, b};
  endfunction

  // ch: 0 = R, 1 = G, 2 = B; column i is band i/W, image column i%W.
  function automatic logic [23:0] exp_col(input int i, input int ch);
    int k, c;
    logic [23:0] p0, p1, p2;
    k  = i / W + 2;
    c  = i % W;
    p0 = pix((k - 2) * W + c);
    p1 = pix((k - 1) * W + c);
    p2 = pix(k * W + c);
    return {p2[8*(2-ch)+:8], p1[8*(2-ch)+:8], p0[8*(2-ch)+:8]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pix(int'(mem_rd_addr));

  initial begin
    col_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) col_ready = 1'b1;
      else if (pat_i < 4) begin
        col_ready = (pat_i == 0 || pat_i == 3);
        pat_i++;
      end else col_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        chk("addr_in_frame", 64'(mem_rd_addr < W * H), 1);
        if (mem_rd_addr >= 2 * W) stream_issued++;
      end
      if (prev_stall)
        chk("stall_stable", 64'({col_r, col_g, col_b, col_eol, col_last}), 64'(saved));
      if (col_valid && col_ready) begin
        if (idx < NCOL) begin
          chk("col_r", col_r, exp_col(idx, 0));
          chk("col_g", col_g, exp_col(idx, 1));
          chk("col_b", col_b, exp_col(idx, 2));
          chk("col_eol", col_eol, (idx % W) == W - 1);
          chk("col_last", col_last, idx == NCOL - 1);
          if (idx == 0) begin first_r = col_r; first_b = col_b; end
          if (idx == NCOL - 1) begin last_r = col_r; last_eol = col_eol; last_last = col_last; end
        end else chk("extra_column", idx, NCOL - 1);
        idx++;
        xfers++;
      end
      if (busy) chk("occ_plus_outstanding_le2", 64'((stream_issued - xfers) <= 2), 1);
      if (done) done_cnt++;
      prev_stall = col_valid && !col_ready;
      saved = {col_r, col_g, col_b, col_eol, col_last};
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1;
    idx = 0; xfers = 0; stream_issued = 0; done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({nm, "_busy_at_done"}, busy, 0);
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_transfers"}, xfers, NCOL);
  endtask

  task automatic pin_literals(input string nm);
    chk({nm, "_first_r"}, first_r, 24'h080400);
    chk({nm, "_first_b"}, first_b, 24'h888480);
    chk({nm, "_last_r"}, last_r, 24'h0F0B07);
    chk({nm, "_last_eol"}, last_eol, 1);
    chk({nm, "_last_last"}, last_last, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; idx = 0; xfers = 0; done_cnt = 0; stream_issued = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'({col_valid, mem_rd_en, busy, done, col_eol, col_last}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Undisturbed frame: PRIME address sequence and first-column latency.
    start_frame();
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      chk("prime_rd", 64'({mem_rd_en, col_valid}), 64'({1'b1, 1'b0}));
      chk("prime_addr", mem_rd_addr, i);
    end
    @(negedge clk);
    chk("first_stream_rd", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, 18'(2 * W)}));
    @(negedge clk);
    chk("valid_not_yet", col_valid, 0);
    @(negedge clk);
    chk("valid_after_2", col_valid, 1);
    wait_done("run1");
    pin_literals("run1");

    // Backpressure: 1,0,0,1 then random.
    ready_mode = 1; pat_i = 0;
    start_frame();
    wait_done("stall");
    ready_mode = 0;

    // Stray start mid-frame.
    start_frame();
    repeat (12) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("restart");
    pin_literals("restart");

    // Reset during band 1, then a clean frame.
    start_frame();
    for (int i = 0; i < 200 && xfers < 5; i++) @(negedge clk);
    chk("reached_band1", 64'(xfers >= 5), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst", 64'({col_valid, busy, done, mem_rd_en}), 0);
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cnt, 0);
    start_frame();
    wait_done("after_rst");
    pin_literals("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
